// File: rtl/vm2002_change_dispenser_if.sv
// rtl/vm2002_change_dispenser_if.sv - request, coin-stream, refill and status bundle for the change dispenser
interface vm2002_change_dispenser_if;
   logic [7:0] balance;
   logic       balance_valid;
   logic [1:0] coin_out;
   logic       coin_valid;
   logic       coin_ready;
   logic       busy;
   logic       done;
   logic       short_change;
   logic [7:0] shortfall;
   logic       misaligned;
   logic       refill_valid;
   logic [1:0] refill_coin;
   logic [7:0] refill_count;
   logic [7:0] stock_q;
   logic [7:0] stock_d;
   logic [7:0] stock_n;

   modport master (
      output balance, balance_valid, coin_ready, refill_valid, refill_coin, refill_count,
      input  coin_out, coin_valid, busy, done, short_change, shortfall, misaligned,
      input  stock_q, stock_d, stock_n
   );

   modport slave (
      input  balance, balance_valid, coin_ready, refill_valid, refill_coin, refill_count,
      output coin_out, coin_valid, busy, done, short_change, shortfall, misaligned,
      output stock_q, stock_d, stock_n
   );
endinterface

// File: rtl/vm2002_change_dispenser.sv
// rtl/vm2002_change_dispenser.sv - greedy coin-change transmitter with per-type stock counters
module vm2002_change_dispenser #(
   parameter logic [7:0] INIT_QUARTERS = 8'd20,
   parameter logic [7:0] INIT_DIMES    = 8'd20,
   parameter logic [7:0] INIT_NICKELS  = 8'd20
) (
   input  logic                          clk,
   input  logic                          hrst_n,
   input  logic                          srst,
   vm2002_change_dispenser_if.slave      bus
);

   typedef enum logic [1:0] {IDLE, DISPENSE, DONE} state_t;

   state_t     state, state_nxt;
   logic [7:0] remaining;
   logic [7:0] stock_q, stock_d, stock_n;
   logic [7:0] shortfall_r;
   logic       misaligned_r;
   logic [1:0] choice;
   logic [7:0] coin_value;
   logic [7:0] bal_mod;
   logic       coin_valid_c, busy_c, done_c;

   function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
      logic [8:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[8] ? 8'hff : sum[7:0];
   endfunction

   assign bal_mod = bus.balance % 8'd5;

   // Greedy pick from registered remaining and stock; an emptied stock is seen on the next pick.
   always_comb begin
      choice     = 2'd0;
      coin_value = 8'd0;
      if (remaining >= 8'd25 && stock_q != 8'd0) begin
         choice     = 2'd3;
         coin_value = 8'd25;
      end else if (remaining >= 8'd10 && stock_d != 8'd0) begin
         choice     = 2'd2;
         coin_value = 8'd10;
      end else if (remaining >= 8'd5 && stock_n != 8'd0) begin
         choice     = 2'd1;
         coin_value = 8'd5;
      end
   end

   always_ff @(posedge clk or negedge hrst_n) begin
      if (!hrst_n)
         state <= IDLE;
      else if (srst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      coin_valid_c = 1'b0;
      busy_c       = 1'b0;
      done_c       = 1'b0;
      case (state)
         IDLE: begin
            if (bus.balance_valid)
               state_nxt = DISPENSE;
         end
         DISPENSE: begin
            busy_c       = 1'b1;
            coin_valid_c = (choice != 2'd0);
            if (choice == 2'd0)
               state_nxt = DONE;
         end
         DONE: begin
            busy_c    = 1'b1;
            done_c    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Stock only changes on an accepted handshake or an IDLE refill; srst keeps stock and status.
   always_ff @(posedge clk or negedge hrst_n) begin
      if (!hrst_n) begin
         remaining    <= 8'd0;
         stock_q      <= INIT_QUARTERS;
         stock_d      <= INIT_DIMES;
         stock_n      <= INIT_NICKELS;
         shortfall_r  <= 8'd0;
         misaligned_r <= 1'b0;
      end else if (srst) begin
         remaining <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.refill_valid) begin
                  case (bus.refill_coin)
                     2'd1:    stock_n <= sat_add(stock_n, bus.refill_count);
                     2'd2:    stock_d <= sat_add(stock_d, bus.refill_count);
                     2'd3:    stock_q <= sat_add(stock_q, bus.refill_count);
                     default: ;
                  endcase
               end
               if (bus.balance_valid) begin
                  remaining    <= bus.balance - bal_mod;
                  misaligned_r <= (bal_mod != 8'd0);
                  shortfall_r  <= 8'd0;
               end
            end
            DISPENSE: begin
               if (choice == 2'd0) begin
                  shortfall_r <= remaining;
               end else if (bus.coin_ready) begin
                  remaining <= remaining - coin_value;
                  case (choice)
                     2'd1:    stock_n <= stock_n - 8'd1;
                     2'd2:    stock_d <= stock_d - 8'd1;
                     default: stock_q <= stock_q - 8'd1;
                  endcase
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.coin_valid   = coin_valid_c;
   assign bus.coin_out     = coin_valid_c ? choice : 2'd0;
   assign bus.busy         = busy_c;
   assign bus.done         = done_c;
   assign bus.short_change = done_c && (shortfall_r != 8'd0);
   assign bus.shortfall    = shortfall_r;
   assign bus.misaligned   = misaligned_r;
   assign bus.stock_q      = stock_q;
   assign bus.stock_d      = stock_d;
   assign bus.stock_n      = stock_n;

endmodule

// File: tb/tb_vm2002_change_dispenser.sv
// tb/tb_vm2002_change_dispenser.sv - directed self-checking bench for vm2002_change_dispenser
module tb_vm2002_change_dispenser;

   logic clk = 1'b0;
   logic hrst_n;
   logic srst;

   always #5 clk = ~clk;

   vm2002_change_dispenser_if bus ();
   vm2002_change_dispenser_if bus2 ();

   vm2002_change_dispenser dut (
      .clk    (clk),
      .hrst_n (hrst_n),
      .srst   (srst),
      .bus    (bus)
   );

   vm2002_change_dispenser #(.INIT_NICKELS(8'd0)) dut2 (
      .clk    (clk),
      .hrst_n (hrst_n),
      .srst   (srst),
      .bus    (bus2)
   );

   int passed = 0;
   int total  = 0;

   logic [1:0] got [8];
   int         ngot;
   bit         seen_done;
   logic       sc_seen;
   logic [7:0] sf_seen;
   int         done_cyc;
   logic       busy0;

   // Issues one request and records accepted coins plus the done-cycle status.
   task automatic run_txn(input bit sel, input logic [7:0] bal, input int budget);
      @(negedge clk);
      if (sel) begin
         bus2.balance = bal; bus2.balance_valid = 1'b1;
      end else begin
         bus.balance = bal; bus.balance_valid = 1'b1;
      end
      @(negedge clk);
      bus.balance_valid  = 1'b0;
      bus2.balance_valid = 1'b0;
      for (int i = 0; i < 8; i++) got[i] = 2'd0;
      ngot = 0; seen_done = 0; done_cyc = -1; sc_seen = 1'b0; sf_seen = 8'd0;
      busy0 = sel ? bus2.busy : bus.busy;
      for (int c = 0; c < budget; c++) begin
         if (sel ? (bus2.coin_valid && bus2.coin_ready) : (bus.coin_valid && bus.coin_ready)) begin
            if (ngot < 8) got[ngot] = sel ? bus2.coin_out : bus.coin_out;
            ngot++;
         end
         if (sel ? bus2.done : bus.done) begin
            seen_done = 1; done_cyc = c;
            sc_seen = sel ? bus2.short_change : bus.short_change;
            sf_seen = sel ? bus2.shortfall : bus.shortfall;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      hrst_n = 1'b0; srst = 1'b0;
      bus.balance = 8'd0; bus.balance_valid = 1'b0; bus.coin_ready = 1'b1;
      bus.refill_valid = 1'b0; bus.refill_coin = 2'd0; bus.refill_count = 8'd0;
      bus2.balance = 8'd0; bus2.balance_valid = 1'b0; bus2.coin_ready = 1'b1;
      bus2.refill_valid = 1'b0; bus2.refill_coin = 2'd0; bus2.refill_count = 8'd0;
      #12;
      total++; if (bus.coin_valid !== 1'b0) $display("FAIL reset_coin_valid got %0d exp 0", bus.coin_valid); else passed++;
      total++; if (bus.coin_out !== 2'd0) $display("FAIL reset_coin_out got %0d exp 0", bus.coin_out); else passed++;
      total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) $display("FAIL reset_busy_done got %0d/%0d exp 0/0", bus.busy, bus.done); else passed++;
      total++; if (bus.shortfall !== 8'd0 || bus.misaligned !== 1'b0) $display("FAIL reset_status got %0d/%0d exp 0/0", bus.shortfall, bus.misaligned); else passed++;
      total++; if (bus.stock_q !== 8'd20 || bus.stock_d !== 8'd20 || bus.stock_n !== 8'd20) $display("FAIL reset_stock got %0d/%0d/%0d exp 20/20/20", bus.stock_q, bus.stock_d, bus.stock_n); else passed++;
      total++; if (bus2.stock_n !== 8'd0) $display("FAIL reset_stock_n_param got %0d exp 0", bus2.stock_n); else passed++;
      @(negedge clk);
      hrst_n = 1'b1;
   endtask

   task automatic test_aligned;
      bus.coin_ready = 1'b1;
      run_txn(0, 8'd65, 20);
      total++; if (busy0 !== 1'b1) $display("FAIL aligned_busy got %0d exp 1", busy0); else passed++;
      total++; if (ngot != 4) $display("FAIL aligned_ncoins got %0d exp 4", ngot); else passed++;
      total++; if (got[0] !== 2'd3 || got[1] !== 2'd3 || got[2] !== 2'd2 || got[3] !== 2'd1)
         $display("FAIL aligned_coins got %0d %0d %0d %0d exp 3 3 2 1", got[0], got[1], got[2], got[3]); else passed++;
      total++; if (done_cyc != 5) $display("FAIL aligned_done_cycle got %0d exp 5", done_cyc); else passed++;
      total++; if (sc_seen !== 1'b0 || sf_seen !== 8'd0) $display("FAIL aligned_short got %0d/%0d exp 0/0", sc_seen, sf_seen); else passed++;
      total++; if (bus.stock_q !== 8'd18 || bus.stock_d !== 8'd19 || bus.stock_n !== 8'd19) $display("FAIL aligned_stock got %0d/%0d/%0d exp 18/19/19", bus.stock_q, bus.stock_d, bus.stock_n); else passed++;
      @(negedge clk);
      total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) $display("FAIL aligned_idle got %0d/%0d exp 0/0", bus.busy, bus.done); else passed++;
   endtask

   task automatic test_misaligned;
      run_txn(0, 8'd47, 20);
      total++; if (bus.misaligned !== 1'b1) $display("FAIL misaligned_flag got %0d exp 1", bus.misaligned); else passed++;
      total++; if (ngot != 3 || got[0] !== 2'd3 || got[1] !== 2'd2 || got[2] !== 2'd2)
         $display("FAIL misaligned_coins got n=%0d %0d %0d %0d exp n=3 3 2 2", ngot, got[0], got[1], got[2]); else passed++;
      total++; if (!seen_done || done_cyc != 4 || sf_seen !== 8'd0) $display("FAIL misaligned_done got cyc=%0d sf=%0d exp cyc=4 sf=0", done_cyc, sf_seen); else passed++;
   endtask

   task automatic test_zero;
      run_txn(0, 8'd0, 10);
      total++; if (ngot != 0 || done_cyc != 1) $display("FAIL zero_balance got n=%0d cyc=%0d exp n=0 cyc=1", ngot, done_cyc); else passed++;
      total++; if (bus.misaligned !== 1'b0 || sc_seen !== 1'b0) $display("FAIL zero_status got %0d/%0d exp 0/0", bus.misaligned, sc_seen); else passed++;
   endtask

   task automatic test_greedy_shortage;
      bus2.coin_ready = 1'b1;
      run_txn(1, 8'd30, 20);
      total++; if (ngot != 1 || got[0] !== 2'd3) $display("FAIL shortage_coins got n=%0d %0d exp n=1 3", ngot, got[0]); else passed++;
      total++; if (!seen_done || done_cyc != 2) $display("FAIL shortage_done got seen=%0d cyc=%0d exp 1/2", seen_done, done_cyc); else passed++;
      total++; if (sc_seen !== 1'b1 || sf_seen !== 8'd5) $display("FAIL shortage_short got %0d/%0d exp 1/5", sc_seen, sf_seen); else passed++;
      total++; if (bus2.stock_q !== 8'd19 || bus2.stock_d !== 8'd20) $display("FAIL shortage_stock got %0d/%0d exp 19/20", bus2.stock_q, bus2.stock_d); else passed++;
   endtask

   task automatic test_backpressure;
      bus.coin_ready = 1'b0;
      @(negedge clk);
      bus.balance = 8'd25; bus.balance_valid = 1'b1;
      @(negedge clk);
      bus.balance_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         total++; if (bus.coin_valid !== 1'b1 || bus.coin_out !== 2'd3 || bus.stock_q !== 8'd17)
            $display("FAIL backpressure_hold%0d got v=%0d c=%0d q=%0d exp 1/3/17", i, bus.coin_valid, bus.coin_out, bus.stock_q); else passed++;
         @(negedge clk);
      end
      bus.coin_ready = 1'b1;
      @(negedge clk);
      total++; if (bus.stock_q !== 8'd16 || bus.coin_valid !== 1'b0) $display("FAIL backpressure_take got q=%0d v=%0d exp 16/0", bus.stock_q, bus.coin_valid); else passed++;
      @(negedge clk);
      total++; if (bus.done !== 1'b1 || bus.short_change !== 1'b0) $display("FAIL backpressure_done got %0d/%0d exp 1/0", bus.done, bus.short_change); else passed++;
   endtask

   task automatic test_abort_and_reset;
      bit done_hit;
      bus.coin_ready = 1'b1;
      @(negedge clk);
      bus.balance = 8'd47; bus.balance_valid = 1'b1;
      @(negedge clk);
      bus.balance_valid = 1'b0;
      total++; if (bus.coin_out !== 2'd3) $display("FAIL abort_first got %0d exp 3", bus.coin_out); else passed++;
      @(negedge clk);
      total++; if (bus.coin_out !== 2'd2 || bus.stock_q !== 8'd15) $display("FAIL abort_second got c=%0d q=%0d exp 2/15", bus.coin_out, bus.stock_q); else passed++;
      srst = 1'b1;
      @(negedge clk);
      srst = 1'b0;
      total++; if (bus.coin_valid !== 1'b0 || bus.busy !== 1'b0) $display("FAIL abort_drop got v=%0d b=%0d exp 0/0", bus.coin_valid, bus.busy); else passed++;
      total++; if (bus.stock_q !== 8'd15 || bus.stock_d !== 8'd17 || bus.misaligned !== 1'b1)
         $display("FAIL abort_kept got q=%0d d=%0d m=%0d exp 15/17/1", bus.stock_q, bus.stock_d, bus.misaligned); else passed++;
      done_hit = 0;
      for (int i = 0; i < 4; i++) begin
         if (bus.done) done_hit = 1;
         @(negedge clk);
      end
      total++; if (done_hit) $display("FAIL abort_no_done got 1 exp 0"); else passed++;

      bus.balance = 8'd47; bus.balance_valid = 1'b1;
      @(negedge clk);
      bus.balance_valid = 1'b0;
      total++; if (bus.coin_valid !== 1'b1) $display("FAIL hrst_pre got %0d exp 1", bus.coin_valid); else passed++;
      #2 hrst_n = 1'b0;
      #1;
      total++; if (bus.coin_valid !== 1'b0 || bus.coin_out !== 2'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0)
         $display("FAIL hrst_outputs got v=%0d c=%0d b=%0d d=%0d exp 0/0/0/0", bus.coin_valid, bus.coin_out, bus.busy, bus.done); else passed++;
      total++; if (bus.misaligned !== 1'b0 || bus.shortfall !== 8'd0) $display("FAIL hrst_status got %0d/%0d exp 0/0", bus.misaligned, bus.shortfall); else passed++;
      total++; if (bus.stock_q !== 8'd20 || bus.stock_d !== 8'd20 || bus.stock_n !== 8'd20)
         $display("FAIL hrst_stock got %0d/%0d/%0d exp 20/20/20", bus.stock_q, bus.stock_d, bus.stock_n); else passed++;
      @(negedge clk);
      hrst_n = 1'b1;
   endtask

   task automatic test_refill;
      @(negedge clk);
      bus.refill_valid = 1'b1; bus.refill_coin = 2'd1; bus.refill_count = 8'd230;
      @(negedge clk);
      total++; if (bus.stock_n !== 8'd250) $display("FAIL refill_add got %0d exp 250", bus.stock_n); else passed++;
      bus.refill_count = 8'd10;
      @(negedge clk);
      total++; if (bus.stock_n !== 8'd255) $display("FAIL refill_saturate got %0d exp 255", bus.stock_n); else passed++;
      bus.refill_coin = 2'd0; bus.refill_count = 8'd50;
      @(negedge clk);
      bus.refill_valid = 1'b0;
      total++; if (bus.stock_q !== 8'd20 || bus.stock_d !== 8'd20 || bus.stock_n !== 8'd255)
         $display("FAIL refill_none got %0d/%0d/%0d exp 20/20/255", bus.stock_q, bus.stock_d, bus.stock_n); else passed++;

      bus.coin_ready = 1'b0;
      bus.balance = 8'd25; bus.balance_valid = 1'b1;
      @(negedge clk);
      bus.balance_valid = 1'b0;
      bus.refill_valid = 1'b1; bus.refill_coin = 2'd3; bus.refill_count = 8'd5;
      @(negedge clk);
      bus.refill_valid = 1'b0;
      total++; if (bus.busy !== 1'b1 || bus.stock_q !== 8'd20) $display("FAIL refill_busy got b=%0d q=%0d exp 1/20", bus.busy, bus.stock_q); else passed++;
      bus.coin_ready = 1'b1;
      @(negedge clk);
      total++; if (bus.stock_q !== 8'd19) $display("FAIL refill_busy_take got %0d exp 19", bus.stock_q); else passed++;
      @(negedge clk);
      total++; if (bus.done !== 1'b1) $display("FAIL refill_busy_done got %0d exp 1", bus.done); else passed++;

      @(negedge clk);
      bus.balance = 8'd10; bus.balance_valid = 1'b1;
      bus.refill_valid = 1'b1; bus.refill_coin = 2'd2; bus.refill_count = 8'd3;
      @(negedge clk);
      bus.balance_valid = 1'b0; bus.refill_valid = 1'b0;
      total++; if (bus.coin_out !== 2'd2 || bus.stock_d !== 8'd23) $display("FAIL refill_same_cycle got c=%0d d=%0d exp 2/23", bus.coin_out, bus.stock_d); else passed++;
      @(negedge clk);
      total++; if (bus.stock_d !== 8'd22) $display("FAIL refill_same_take got %0d exp 22", bus.stock_d); else passed++;
      @(negedge clk);
      total++; if (bus.done !== 1'b1 || bus.short_change !== 1'b0) $display("FAIL refill_same_done got %0d/%0d exp 1/0", bus.done, bus.short_change); else passed++;
   endtask

   initial begin
      test_reset();
      test_aligned();
      test_misaligned();
      test_zero();
      test_greedy_shortage();
      test_backpressure();
      test_abort_and_reset();
      test_refill();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
